// File: rtl/sipo_rx.sv
// sipo_rx -- UART receive serial-to-parallel converter.
// Recovers 11-bit frames (start, 8 data LSB first, parity, stop) from an
// asynchronous rx line sampled by an OSR x baud clock, and presents the byte,
// the received parity bit and error flags with a one-cycle rx_valid strobe.
// Optional build macro: RX_MAJORITY_VOTE_EN (2-of-3 vote around each bit centre).
//
// Handshake: rx_valid is a one-cycle strobe with no ready/backpressure; the
// byte and flags are valid with it and hold until the next strobe. The host
// must take them within 10*OSR cycles.
//
// Debug: the FSM state register `state` (type state_t) is visible for binding.
module sipo_rx #(
  parameter int OSR        = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       bd_clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       parity_bit,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active
);

  localparam int TW = $clog2(OSR);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic [TW-1:0] BIT_TICK = TW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t          state, state_d;
  logic            sync1, rx_s, rx_d;
  logic [TW-1:0]   tick, tick_d;
  logic [2:0]      bit_cnt, bit_d;
  logic [7:0]      shift, shift_d;
  logic            par_q, par_d;
  logic            done;
  logic            bit_val;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // The decision is taken one tick after the centre, so every sample point
  // (start included) moves one cycle later and the vote window is
  // centre-1, centre, centre+1.
  localparam logic [TW-1:0] START_TICK = TW'(OSR / 2);
  logic [1:0] hist;

  // Short history of rx_s: hist[1] = centre-1, hist[0] = centre at decision time.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam logic [TW-1:0] START_TICK = TW'(OSR / 2 - 1);
  assign bit_val = rx_s;
`endif

  assign active = (state != IDLE);

  // FSM state and datapath registers.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_d;
      tick    <= tick_d;
      bit_cnt <= bit_d;
      shift   <= shift_d;
      par_q   <= par_d;
    end
  end

  // Next-state and datapath updates; each bit decision resets the tick counter.
  always_comb begin
    state_d = state;
    tick_d  = tick;
    bit_d   = bit_cnt;
    shift_d = shift;
    par_d   = par_q;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick == START_TICK) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      DATA: begin
        if (tick == BIT_TICK) begin
          tick_d  = '0;
          shift_d = {bit_val, shift[7:1]};
          if (bit_cnt == 3'd7) state_d = PARITY;
          else                 bit_d   = bit_cnt + 3'd1;
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      PARITY: begin
        if (tick == BIT_TICK) begin
          tick_d  = '0;
          par_d   = bit_val;
          state_d = STOP;
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      STOP: begin
        if (tick == BIT_TICK) begin
          tick_d  = '0;
          done    = 1'b1;
          state_d = bit_val ? IDLE : BREAK;
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Host-facing outputs: loaded at the stop-bit decision, held otherwise.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      parity_bit <= 1'b0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= done;
      if (done) begin
        data_out   <= shift;
        parity_bit <= par_q;
        parity_err <= (^shift) ^ par_q ^ ODD;
        frame_err  <= ~bit_val;
      end
    end
  end

endmodule
